// File: rtl/mips_cache_pkg.sv
// Shared types, geometry and address field helpers for the direct-mapped data cache.
// Default geometry: 8 lines x 4 words, 32-bit byte addresses.
package mips_cache_pkg;

    localparam int NUM_LINES_D      = 8;
    localparam int WORDS_PER_LINE_D = 4;
    localparam int ADDR_WIDTH_D     = 32;

    localparam int OFFSET_W = $clog2(WORDS_PER_LINE_D);
    localparam int INDEX_W  = $clog2(NUM_LINES_D);
    localparam int TAG_W    = ADDR_WIDTH_D - INDEX_W - OFFSET_W - 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    function automatic logic [OFFSET_W-1:0] addr_word(input logic [ADDR_WIDTH_D-1:0] addr);
        return addr[OFFSET_W+1:2];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_WIDTH_D-1:0] addr);
        return addr[INDEX_W+OFFSET_W+1:OFFSET_W+2];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_WIDTH_D-1:0] addr);
        return addr[ADDR_WIDTH_D-1:INDEX_W+OFFSET_W+2];
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays of the data cache: combinational read by index, word write,
// tag/valid set and per-line invalidate. Only the valid bits are cleared by reset.
module dcache_line_store #(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 25,
    parameter int IW             = $clog2(NUM_LINES),
    parameter int OW             = $clog2(WORDS_PER_LINE)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    rd_index,
    input  logic [OW-1:0]    rd_word,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_index,
    input  logic [OW-1:0]    wr_word,
    input  logic [31:0]      wr_data,
    input  logic             set_en,
    input  logic [IW-1:0]    set_index,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_en,
    input  logic [IW-1:0]    clr_index
);

    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [31:0]          data_r [NUM_LINES][WORDS_PER_LINE];

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_data  = data_r[rd_index][rd_word];

    // Valid bits: cleared by reset, dropped when a refill starts, set when it completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_r <= '0;
        end else if (set_en) begin
            valid_r[set_index] <= 1'b1;
        end else if (clr_en) begin
            valid_r[clr_index] <= 1'b0;
        end
    end

    // Tag array, written only when a line refill completes.
    always_ff @(posedge clk) begin
        if (reset && set_en) begin
            tag_r[set_index] <= set_tag;
        end
    end

    // Data array, written by refill words and store hits.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            data_r[wr_index][wr_word] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with burst refill.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
    import mips_cache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
)(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           Write_Data,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    output logic [31:0]           Read_data,
    output logic                  Stall,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic [31:0]           Mem_Write_Data,
    output logic                  Mem_MemWrite,
    output logic                  Mem_MemRead,
    input  logic [31:0]           Mem_Read_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           Hit_count,
    output logic [31:0]           Miss_count
`endif
);

    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = ADDR_WIDTH - IW - OW - 2;

    state_t        state_r;
    state_t        state_nx_s;
    logic [OW-1:0] cnt_r;
    logic [TW-1:0] miss_tag_r;
    logic [IW-1:0] miss_index_r;

    logic [OW-1:0] req_word_s;
    logic [IW-1:0] req_index_s;
    logic [TW-1:0] req_tag_s;

    logic          rd_valid_s;
    logic [TW-1:0] rd_tag_s;
    logic [31:0]   rd_data_s;
    logic          hit_s;

    logic          wr_en_s;
    logic [IW-1:0] wr_index_s;
    logic [OW-1:0] wr_word_s;
    logic [31:0]   wr_data_s;
    logic          set_en_s;
    logic          miss_latch_s;
    logic          load_hit_s;
    logic          cnt_inc_s;

    assign req_word_s  = addr_word(Address);
    assign req_index_s = addr_index(Address);
    assign req_tag_s   = addr_tag(Address);
    assign hit_s       = rd_valid_s && (rd_tag_s == req_tag_s);

    dcache_line_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TW),
        .IW             (IW),
        .OW             (OW)
    ) u_line_store (
        .clk       (CLK),
        .reset     (RESET),
        .rd_index  (req_index_s),
        .rd_word   (req_word_s),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_data   (rd_data_s),
        .wr_en     (wr_en_s),
        .wr_index  (wr_index_s),
        .wr_word   (wr_word_s),
        .wr_data   (wr_data_s),
        .set_en    (set_en_s),
        .set_index (miss_index_r),
        .set_tag   (miss_tag_r),
        .clr_en    (miss_latch_s),
        .clr_index (req_index_s)
    );

    // Next state, array write controls and all memory/CPU outputs; everything is zero in reset.
    always_comb begin
        state_nx_s     = state_r;
        Read_data      = 32'd0;
        Stall          = 1'b0;
        Mem_Address    = '0;
        Mem_Write_Data = 32'd0;
        Mem_MemWrite   = 1'b0;
        Mem_MemRead    = 1'b0;
        wr_en_s        = 1'b0;
        wr_index_s     = req_index_s;
        wr_word_s      = req_word_s;
        wr_data_s      = Write_Data;
        set_en_s       = 1'b0;
        miss_latch_s   = 1'b0;
        load_hit_s     = 1'b0;
        cnt_inc_s      = 1'b0;
        if (!RESET) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (MemWrite) begin
                        Mem_MemWrite   = 1'b1;
                        Mem_Address    = Address;
                        Mem_Write_Data = Write_Data;
                        wr_en_s        = hit_s;
                    end else if (MemRead) begin
                        if (hit_s) begin
                            Read_data  = rd_data_s;
                            load_hit_s = 1'b1;
                        end else begin
                            Stall        = 1'b1;
                            miss_latch_s = 1'b1;
                            state_nx_s   = REFILL;
                        end
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                REFILL: begin
                    Stall       = 1'b1;
                    Mem_MemRead = 1'b1;
                    Mem_Address = {miss_tag_r, miss_index_r, cnt_r, 2'b00};
                    wr_en_s     = 1'b1;
                    wr_index_s  = miss_index_r;
                    wr_word_s   = cnt_r;
                    wr_data_s   = Mem_Read_data;
                    cnt_inc_s   = 1'b1;
                    if (cnt_r == OW'(WORDS_PER_LINE - 1)) begin
                        set_en_s   = 1'b1;
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = REFILL;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // State register, refill word counter and latched miss line address.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            miss_tag_r   <= '0;
            miss_index_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if (miss_latch_s) begin
                cnt_r        <= '0;
                miss_tag_r   <= req_tag_s;
                miss_index_r <= req_index_s;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + OW'(1);
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Saturating load-hit and miss-detection counters.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if (load_hit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if (miss_latch_s && (miss_count_r != 32'hFFFF_FFFF)) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign Hit_count  = RESET ? hit_count_r  : 32'd0;
    assign Miss_count = RESET ? miss_count_r : 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: word memory model plus an abstract cache model.
module tb_dcache_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Address;
    logic [31:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_data;
    logic        Stall;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_Write_Data;
    logic        Mem_MemWrite;
    logic        Mem_MemRead;
    logic [31:0] Mem_Read_data;
`ifdef DCACHE_STATS_EN
    logic [31:0] Hit_count;
    logic [31:0] Miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:1023];
    bit          m_valid [8];
    int          m_tag   [8];
    logic [31:0] m_data  [8][4];

    dcache_ctrl dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Address        (Address),
        .Write_Data     (Write_Data),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .Read_data      (Read_data),
        .Stall          (Stall),
        .Mem_Address    (Mem_Address),
        .Mem_Write_Data (Mem_Write_Data),
        .Mem_MemWrite   (Mem_MemWrite),
        .Mem_MemRead    (Mem_MemRead),
        .Mem_Read_data  (Mem_Read_data)
`ifdef DCACHE_STATS_EN
        ,
        .Hit_count      (Hit_count),
        .Miss_count     (Miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    assign Mem_Read_data = mem[Mem_Address[11:2]];

    always @(posedge CLK) begin
        if (Mem_MemWrite) mem[Mem_Address[11:2]] <= Mem_Write_Data;
    end

    function automatic int f_idx(input logic [31:0] a);
        return int'((a / 16) % 8);
    endfunction
    function automatic int f_tag(input logic [31:0] a);
        return int'(a / 128);
    endfunction
    function automatic int f_word(input logic [31:0] a);
        return int'((a / 4) % 4);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic apply_reset();
        RESET = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        clear_model();
    endtask

    // One CPU request held until the model says it completes; addresses must stay below 4096.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input string nm);
        int  idx;
        int  w;
        bit  hit;
        logic [31:0] exp_addr;
        Address = a; Write_Data = d; MemRead = rd; MemWrite = wr;
        idx = f_idx(a);
        w   = f_word(a);
        hit = m_valid[idx] && (m_tag[idx] == f_tag(a));
        @(negedge CLK);
        if (wr) begin
            checks++;
            if (Mem_MemWrite !== 1'b1 || Mem_MemRead !== 1'b0 || Stall !== 1'b0 ||
                Mem_Address !== a || Mem_Write_Data !== d || Read_data !== 32'd0) begin
                failures++;
                $display("FAIL %s_store got we=%b re=%b stall=%b addr=%h wd=%h rd=%h want we=1 re=0 stall=0 addr=%h wd=%h rd=0",
                         nm, Mem_MemWrite, Mem_MemRead, Stall, Mem_Address, Mem_Write_Data, Read_data, a, d);
            end
            if (hit) m_data[idx][w] = d;
            @(posedge CLK); #1;
        end else if (rd) begin
            if (!hit) begin
                checks++;
                if (Stall !== 1'b1 || Mem_MemRead !== 1'b0 || Mem_MemWrite !== 1'b0 || Read_data !== 32'd0) begin
                    failures++;
                    $display("FAIL %s_miss_detect got stall=%b re=%b we=%b rd=%h want stall=1 re=0 we=0 rd=0",
                             nm, Stall, Mem_MemRead, Mem_MemWrite, Read_data);
                end
                @(posedge CLK); #1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge CLK);
                    exp_addr = (a / 16) * 16 + 32'(k * 4);
                    checks++;
                    if (Stall !== 1'b1 || Mem_MemRead !== 1'b1 || Mem_MemWrite !== 1'b0 ||
                        Read_data !== 32'd0 || Mem_Address !== exp_addr) begin
                        failures++;
                        $display("FAIL %s_refill%0d got stall=%b re=%b we=%b rd=%h addr=%h want stall=1 re=1 we=0 rd=0 addr=%h",
                                 nm, k, Stall, Mem_MemRead, Mem_MemWrite, Read_data, Mem_Address, exp_addr);
                    end
                    @(posedge CLK); #1;
                end
                for (int k = 0; k < 4; k++) m_data[idx][k] = mem[((a / 16) * 4 + 32'(k)) % 1024];
                m_valid[idx] = 1'b1;
                m_tag[idx]   = f_tag(a);
                @(negedge CLK);
            end
            checks++;
            if (Stall !== 1'b0 || Mem_MemRead !== 1'b0 || Mem_MemWrite !== 1'b0 || Read_data !== m_data[idx][w]) begin
                failures++;
                $display("FAIL %s_hit got stall=%b re=%b we=%b rd=%h want stall=0 re=0 we=0 rd=%h",
                         nm, Stall, Mem_MemRead, Mem_MemWrite, Read_data, m_data[idx][w]);
            end
            @(posedge CLK); #1;
        end else begin
            checks++;
            if (Stall !== 1'b0 || Mem_MemRead !== 1'b0 || Mem_MemWrite !== 1'b0 || Read_data !== 32'd0) begin
                failures++;
                $display("FAIL %s_idle got stall=%b re=%b we=%b rd=%h want all 0",
                         nm, Stall, Mem_MemRead, Mem_MemWrite, Read_data);
            end
            @(posedge CLK); #1;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; MemRead = 1'b1; MemWrite = 1'b1;
        Address = 32'h40; Write_Data = 32'hCAFE_F00D;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (Read_data !== 32'd0 || Stall !== 1'b0 || Mem_Address !== 32'd0 || Mem_Write_Data !== 32'd0 ||
            Mem_MemWrite !== 1'b0 || Mem_MemRead !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got rd=%h stall=%b addr=%h wd=%h we=%b re=%b want all 0",
                     Read_data, Stall, Mem_Address, Mem_Write_Data, Mem_MemWrite, Mem_MemRead);
        end
        @(posedge CLK); #1;
        RESET = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        clear_model();
    endtask

    task automatic test_miss_fill();
        do_op(1'b1, 1'b0, 32'h40, 32'd0, "fill40");
    endtask

    task automatic test_hit();
        do_op(1'b1, 1'b0, 32'h44, 32'd0, "hit44");
        checks++;
        if (m_data[4][1] !== 32'h1234) begin
            failures++;
            $display("FAIL hit44_value got %h want 00001234", m_data[4][1]);
        end
    endtask

    task automatic test_store();
        do_op(1'b0, 1'b1, 32'h48, 32'hDEAD_BEEF, "st48");
        do_op(1'b1, 1'b0, 32'h48, 32'd0, "ld48");
        do_op(1'b0, 1'b1, 32'h100, 32'h0BAD_F00D, "st100");
        do_op(1'b1, 1'b0, 32'h100, 32'd0, "ld100");
        do_op(1'b1, 1'b1, 32'h4C, 32'h5555_AAAA, "both4c");
        do_op(1'b1, 1'b0, 32'h4C, 32'd0, "ld4c");
    endtask

    task automatic test_conflict();
        do_op(1'b1, 1'b0, 32'hC0, 32'd0, "confC0");
        do_op(1'b1, 1'b0, 32'h40, 32'd0, "conf40");
    endtask

    task automatic test_reset_mid_refill();
        Address = 32'h240; MemRead = 1'b1; MemWrite = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (Read_data !== 32'd0 || Stall !== 1'b0 || Mem_Address !== 32'd0 || Mem_Write_Data !== 32'd0 ||
            Mem_MemWrite !== 1'b0 || Mem_MemRead !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got rd=%h stall=%b addr=%h wd=%h we=%b re=%b want all 0",
                     Read_data, Stall, Mem_Address, Mem_Write_Data, Mem_MemWrite, Mem_MemRead);
        end
        @(posedge CLK); #1;
        RESET = 1'b1;
        clear_model();
        do_op(1'b1, 1'b0, 32'h240, 32'd0, "midreset_reload");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          kind;
        for (int n = 0; n < 80; n++) begin
            a    = 32'($urandom_range(0, 127) * 4 + $urandom_range(0, 3));
            kind = int'($urandom_range(0, 3));
            do_op(kind[0], kind[1], a, $urandom, "rand");
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        apply_reset();
        do_op(1'b1, 1'b0, 32'h40, 32'd0, "stats_miss");
        do_op(1'b1, 1'b0, 32'h44, 32'd0, "stats_hit1");
        do_op(1'b1, 1'b0, 32'h48, 32'd0, "stats_hit2");
        checks++;
        if (Miss_count !== 32'd1 || Hit_count !== 32'd3) begin
            failures++;
            $display("FAIL stats_counts got miss=%0d hit=%0d want miss=1 hit=3", Miss_count, Hit_count);
        end
        apply_reset();
        @(negedge CLK);
        checks++;
        if (Miss_count !== 32'd0 || Hit_count !== 32'd0) begin
            failures++;
            $display("FAIL stats_clear got miss=%0d hit=%0d want 0 0", Miss_count, Hit_count);
        end
        @(posedge CLK); #1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[17] = 32'h0000_1234;
        RESET = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = 32'd0; Write_Data = 32'd0;
        @(posedge CLK); #1;
        test_reset();
        test_miss_fill();
        test_hit();
        test_store();
        test_conflict();
        test_reset_mid_refill();
        test_random();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller between the MEM pipeline stage and the word-addressed data memory.
- It serves CPU loads from a local line array and fills missing lines from memory in bursts.
- It forwards every store to memory. It asserts Stall while the pipeline must hold.

Parameters:
- NUM_LINES, 8, number of cache lines (power of two).
- WORDS_PER_LINE, 4, 32-bit words per line (power of two).
- ADDR_WIDTH, 32, byte-address width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-low reset (sampled on posedge CLK).
- Address  in  32  CPU byte address. Fields: byte [1:0], word [3:2], index [6:4], tag [31:7] at defaults.
- Write_Data  in  32  CPU store data.
- MemWrite  in  1  CPU store request.
- MemRead  in  1  CPU load request.
- Read_data  out  32  load data.
- Stall  out  1  pipeline hold.
- Mem_Address  out  32  byte address to data memory.
- Mem_Write_Data  out  32  store data to memory.
- Mem_MemWrite  out  1  memory write strobe.
- Mem_MemRead  out  1  memory read enable.
- Mem_Read_data  in  32  memory read data, combinational, valid in the same cycle.

Behaviour:
- Reset (RESET=0 at posedge):
  - All valid bits cleared; FSM goes to IDLE; refill counter = 0.
  - While RESET=0, all outputs are 0.
  - Tag and data arrays are not cleared.
- FSM states: IDLE, REFILL.
- IDLE, load hit (MemRead=1, MemWrite=0, valid[index]=1, tag match):
  - Read_data = line word, combinationally in the same cycle.
  - Stall = 0; zero-latency hit.
- IDLE, load miss:
  - Stall = 1 combinationally.
  - Latch {tag, index}; counter = 0; next state REFILL.
  - Mem_MemRead = 0 in this cycle.
- REFILL, each cycle k = 0..WORDS_PER_LINE-1:
  - Mem_MemRead = 1.
  - Mem_Address = {latched tag, latched index, k, 2'b00}.
  - Word k ← Mem_Read_data at posedge.
  - Stall = 1; Read_data = 0.
  - On the last word: valid[index] ← 1, tag ← latched tag, next state IDLE.
  - The CPU holds its request, so the following IDLE cycle is a hit.
  - Total Stall per miss = 1 + WORDS_PER_LINE cycles (5 at defaults).
- IDLE, store (MemWrite=1):
  - Mem_MemWrite = 1, Mem_Address = Address, Mem_Write_Data = Write_Data, all combinationally.
  - On a hit, the cached word is also updated at the same posedge.
  - On a miss, the cache is unchanged (no allocate).
  - Stall = 0.
- MemWrite=1 and MemRead=1 together: treated as a store; Read_data = 0.
- No request, or not in a hit cycle: Read_data = 0.
- Mem_MemWrite is never asserted in REFILL. CPU inputs are ignored in REFILL.
- RESET low mid-refill: refill aborts, the partially filled line stays invalid, state returns to IDLE.
- Address bits [1:0] are ignored (word accesses only).

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs Hit_count[31:0] and Miss_count[31:0].
  - Counts increment once per load hit cycle in IDLE and once per miss detection.
  - Counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mips_cache_pkg holds:
  - the state enum (IDLE, REFILL);
  - localparams for OFFSET_W, INDEX_W, TAG_W, derived from the parameters;
  - address field-extract functions.
- Sub-module dcache_line_store holds the valid/tag/data arrays:
  - combinational read port by index;
  - word write port;
  - tag/valid set port;
  - clear-valid on reset.

Test Plan:
- Reset, then load 0x40 → Stall high 5 cycles; Mem_Address sequence 0x40, 0x44, 0x48, 0x4C; next cycle Stall=0 and Read_data = memory word 16.
- Preload memory word 17 = 0x1234; after line 0x40 is filled, load 0x44 → same-cycle Read_data=0x1234, Stall=0, Mem_MemRead=0.
- Store 0xDEADBEEF to 0x48 (hit) → Mem_MemWrite=1 with Mem_Address=0x48; subsequent load 0x48 hits with 0xDEADBEEF. Store to 0x100 (miss) → memory written, a later load of 0x100 misses.
- Conflict: fill 0x40, then load 0xC0 (same index 4, different tag) → miss refill from 0xC0; reload 0x40 → miss again.
- Drive RESET low during the 2nd refill cycle → outputs 0, state IDLE; repeating the load takes the full 5-cycle miss.
- With DCACHE_STATS_EN: 1 miss + 3 hits → Miss_count=1, Hit_count=3; reset clears both.
